// File: rtl/bcd2bin.sv
// bcd2bin: sequential BCD-to-binary converter using reverse double dabble.
// One shift-right-and-adjust step per clock, BIN_W steps per conversion.
//
// Parameters:
//   DIGITS - number of packed BCD digits on i_bcd
//   BIN_W  - result width, must satisfy 2**BIN_W >= 10**DIGITS
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   i_start - conversion request, sampled only when idle
//   i_bcd   - packed BCD input, digit k at [4k+3:4k], sampled with i_start
//   o_bin   - binary result, held until the next conversion completes
//   o_busy  - conversion in progress
//   o_done  - one-cycle pulse when o_bin/o_err are updated
//   o_err   - accepted input held a digit > 9 (o_bin forced to 0)
module bcd2bin #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_bcd,
  output logic [BIN_W-1:0]      o_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            r_state,  w_state_nxt;
  logic [BcdW-1:0]   r_bcd_sh, w_bcd_sh_nxt;
  logic [BIN_W-1:0]  r_bin_sh, w_bin_sh_nxt;
  logic [CntW-1:0]   r_cnt,    w_cnt_nxt;
  logic              r_bad,    w_bad_nxt;
  logic [BIN_W-1:0]  r_bin,    w_bin_nxt;
  logic              r_busy,   w_busy_nxt;
  logic              r_done,   w_done_nxt;
  logic              r_err,    w_err_nxt;

  logic [BcdW-1:0]   w_bcd_step;
  logic [BIN_W-1:0]  w_bin_step;
  logic              w_in_bad;

  // One reverse double-dabble step: shift right, then pull every digit that
  // reached 8 or more back by 3 so each digit stays a valid halved decimal.
  always_comb begin
    logic [BcdW-1:0] shifted;
    logic [3:0]      dig;
    shifted    = {1'b0, r_bcd_sh[BcdW-1:1]};
    w_bin_step = {r_bcd_sh[0], r_bin_sh[BIN_W-1:1]};
    w_bcd_step = shifted;
    for (int k = 0; k < int'(DIGITS); k++) begin
      dig = shifted[4*k +: 4];
      if (dig >= 4'd8) begin
        w_bcd_step[4*k +: 4] = dig - 4'd3;
      end
    end
  end

  always_comb begin
    w_in_bad = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (i_bcd[4*k +: 4] > 4'd9) begin
        w_in_bad = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bcd_sh_nxt = r_bcd_sh;
    w_bin_sh_nxt = r_bin_sh;
    w_cnt_nxt    = r_cnt;
    w_bad_nxt    = r_bad;
    w_bin_nxt    = r_bin;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_bcd_sh_nxt = i_bcd;
          w_bin_sh_nxt = '0;
          w_bad_nxt    = w_in_bad;
          w_cnt_nxt    = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = StShift;
        end
      end
      StShift: begin
        w_bcd_sh_nxt = w_bcd_step;
        w_bin_sh_nxt = w_bin_step;
        w_cnt_nxt    = r_cnt + 1'b1;
        if (r_cnt == LastCnt) begin
          w_bin_nxt   = r_bad ? '0 : w_bin_step;
          w_err_nxt   = r_bad;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_bcd_sh <= '0;
      r_bin_sh <= '0;
      r_cnt    <= '0;
      r_bad    <= 1'b0;
      r_bin    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bcd_sh <= w_bcd_sh_nxt;
      r_bin_sh <= w_bin_sh_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bad    <= w_bad_nxt;
      r_bin    <= w_bin_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign o_bin  = r_bin;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: randomized and directed self-checking bench for bcd2bin.
module tb_bcd2bin;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [11:0]       bcd;
  logic [BIN_W-1:0]  bin;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;

  bcd2bin #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_bcd   (bcd),
    .o_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: decimal value as sum of digit*10^k; any digit above 9 flags error.
  function automatic void ref_model(input logic [11:0] b, output int val, output bit bad);
    int scale;
    int d;
    val   = 0;
    bad   = 1'b0;
    scale = 1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      d = int'((b >> (4 * k)) & 12'hF);
      if (d > 9) bad = 1'b1;
      val += d * scale;
      scale *= 10;
    end
    if (bad) val = 0;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    logic [3:0] d2, d1, d0;
    d2 = 4'(n / 100);
    d1 = 4'((n / 10) % 10);
    d0 = 4'(n % 10);
    return {d2, d1, d0};
  endfunction

  // Issues start at the next edge (E0) and returns #1 after the done edge,
  // so an immediately following call forms a back-to-back conversion.
  task automatic conv(input logic [11:0] b, input string tag);
    int exp_v;
    bit exp_bad;
    int lat;
    bit got;
    bit busy_ok;
    ref_model(b, exp_v, exp_bad);
    bcd   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    bcd     = 12'($urandom);
    busy_ok = busy;
    lat     = 0;
    got     = 1'b0;
    while (!got && lat < int'(BIN_W) + 4) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check({tag, ":latency"}, 32'(lat), 32'(BIN_W));
    check({tag, ":busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, ":busy_end"}, 32'(busy), 32'd0);
    check({tag, ":bin"}, 32'(bin), 32'(exp_v));
    check({tag, ":err"}, 32'(err), 32'(exp_bad));
  endtask

  initial begin
    int ndone;
    int dcyc;
    int bin_at_done;
    logic [11:0] rb;
    logic [3:0]  dg;

    rst_n = 1'b0;
    start = 1'b0;
    bcd   = '0;
    #12;
    check("rst:bin", 32'(bin), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    conv(12'h000, "zero");
    @(posedge clk); #1;
    check("zero:done_fall", 32'(done), 32'd0);
    check("zero:bin_held", 32'(bin), 32'd0);

    conv(12'h999, "d999");
    conv(12'h255, "d255");

    for (int n = 0; n < 256; n++) conv(to_bcd(n), "roundtrip");
    for (int n = 0; n < 1000; n++) conv(to_bcd(n), "all3dig");

    conv(12'h9A0, "bad9A0");
    conv(12'h001, "after_bad");
    @(posedge clk); #1;

    // Start re-asserted mid-conversion must be ignored.
    bcd   = 12'h456;
    start = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    ndone       = 0;
    dcyc        = 0;
    bin_at_done = 0;
    for (int c = 1; c <= 15; c++) begin
      start = (c == 3 || c == 7);
      if (start) bcd = 12'h123;
      @(posedge clk); #1;
      if (c == 5) check("ignore:bin_stable", 32'(bin), 32'd1);
      if (done) begin
        ndone++;
        dcyc        = c;
        bin_at_done = int'(bin);
      end
    end
    start = 1'b0;
    check("ignore:ndone", 32'(ndone), 32'd1);
    check("ignore:done_cycle", 32'(dcyc), 32'(BIN_W));
    check("ignore:bin", 32'(bin_at_done), 32'd456);
    check("ignore:bin_final", 32'(bin), 32'd456);

    // Asynchronous reset in the middle of a conversion.
    bcd   = 12'h789;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:done", 32'(done), 32'd0);
    check("midrst:bin", 32'(bin), 32'd0);
    check("midrst:err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst:no_done", 32'(ndone), 32'd0);
    check("midrst:idle", 32'(busy), 32'd0);
    conv(12'h042, "after_rst");

    // Random words, biased so roughly a quarter of digits are invalid.
    for (int i = 0; i < 300; i++) begin
      rb = '0;
      for (int k = 0; k < int'(DIGITS); k++) begin
        if ($urandom_range(0, 3) == 0) dg = 4'($urandom_range(10, 15));
        else dg = 4'($urandom_range(0, 9));
        rb = rb | (12'(dg) << (4 * k));
      end
      conv(rb, "random");
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd2bin.md
# bcd2bin

Sequential BCD-to-binary converter: the inverse of the combinational binary-to-BCD encoder in the display path. It accepts a packed BCD word from keypad/operand entry and produces the unsigned binary value the ALU consumes. It uses reverse double dabble: one shift-right-and-adjust step per clock, with a start/busy/done handshake.

## Interface
- `DIGITS`, default 3: number of BCD digits in the input.
- `BIN_W`, default 10: width of the binary result. It must satisfy 2^BIN_W ≥ 10^DIGITS. The default 10 covers 999.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a conversion. Sampled only in IDLE.
- `bcd` in 4*DIGITS: packed BCD input. Digit k occupies [4k+3:4k]; digit 0 is the least significant. Sampled only on the edge that accepts `start`.
- `bin` out BIN_W: conversion result. Held until the next accepted conversion completes.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse marking `bin`/`err` valid.
- `err` out 1: high when the accepted `bcd` contained a digit > 9. Updated with `done` and held until the next `done`.

## Operation
- Internal state:
  - Working register `{bcd_sh[4*DIGITS-1:0], bin_sh[BIN_W-1:0]}`.
  - Step counter `cnt`, width ceil(log2(BIN_W))+1.
  - Two-state FSM: IDLE, SHIFT.
- IDLE:
  - On `start`=1: load `bcd_sh`←`bcd` and `bin_sh`←0.
  - Capture `bad` = OR over digits of (digit > 9).
  - Set `cnt`←0, `busy`←1, go to SHIFT.
  - On `start`=0: hold.
- SHIFT, one step per cycle:
  - Shift the whole working register right by 1. The LSB of `bcd_sh` enters the MSB of `bin_sh`; zero enters the MSB of `bcd_sh`.
  - Then, for every digit of the shifted `bcd_sh` with value ≥ 8, subtract 3 (4-bit, no borrow into neighbours).
  - Adjust is applied after every shift, including the last.
  - `cnt`←`cnt`+1.
- Completion, on the step where `cnt` == BIN_W-1:
  - `bin` ← final `bin_sh` value, or 0 if `bad`.
  - `err` ← `bad`.
  - `done`←1, `busy`←0, go to IDLE.
- `done` returns to 0 on the following edge unconditionally.
- `start` while `busy`=1 is ignored. It is not queued.
- `start` in the cycle `done`=1 is accepted, since the FSM is already in IDLE. This gives back-to-back conversions every BIN_W+1 cycles.
- Invalid digits do not abort the conversion; the full step count still runs so latency is fixed.
- The result is unsigned. For valid input it equals Σ digit_k·10^k exactly, with no truncation given the `BIN_W` constraint.

## Timing
- Reset (`rst_n`=0, asynchronous): FSM=IDLE, `bin`=0, `busy`=0, `done`=0, `err`=0, `cnt`=0, working register=0.
- Reset mid-conversion aborts immediately. No `done` is produced, and outputs take their reset values.
- Let E0 be the edge that samples `start` in IDLE:
  - `busy` is high from E0 to E_BIN_W.
  - Shift steps occur on edges E1…E_BIN_W.
  - `bin`/`err` update and `done` rises at E_BIN_W; `done` falls at E_BIN_W+1.
  - Latency from `start` to `done` is BIN_W cycles; default 10.
- `bcd` may change freely after E0 without affecting the result.
- `bin`/`err` are stable from E_BIN_W until the next conversion's `done` edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `bcd`=12'h000 with `start` pulse → `done` 10 cycles later, `bin`=0, `err`=0; `busy` high for exactly 10 cycles.
- `bcd`=12'h999 → `bin`=10'd999 (0x3E7), `err`=0. `bcd`=12'h255 → `bin`=255, matching the encoder's output for 8'hFF.
- Exhaustive round trip: for n=0…255, feed the encoder's BCD output into this block → `bin`==n. Additionally, every valid 3-digit BCD 000…999 → correct value, using back-to-back `start` issued in the `done` cycle (one conversion per 11 cycles).
- `bcd`=12'h9A0 (middle digit 10) → `done` after 10 cycles with `err`=1, `bin`=0. A subsequent `bcd`=12'h001 → `err`=0, `bin`=1.
- `start` re-asserted with `bcd`=12'h123 at cycles 3 and 7 of a conversion of 12'h456 → single `done`, `bin`=456, no second `done` pulse.
- `rst_n` pulsed low at cycle 5 of a conversion → `busy`, `done`, `bin`, `err` go to 0 immediately. No `done` appears afterward, and a fresh `start` with 12'h042 yields `bin`=42.
